// File: rtl/dcache_axi_bridge.sv
// -----------------------------------------------------------------------------
// dcache_axi_bridge
//   AXI4 master-side bridge for the dcache s2 request interface. It accepts
//   single-cycle request pulses and runs each one as a single AXI transaction:
//   a cached line read (INCR burst), a cached line write-back (INCR burst), or
//   an uncached single-word read or write. It returns a done pulse for each
//   transaction, and for reads the assembled line.
//
//   Optional feature macro: DCACHE_AXI_RESP_CHK_EN
//     Adds the sticky output bus_err_o. It is set by any accepted R beat or B
//     response that has a non-OKAY response code, or whose ID is not AXI_ID.
//
// Ports
//   clk, rst_n            clock (posedge), asynchronous active-low reset
//   ca_rreq_i/ca_wreq_i   cached line read / dirty-line write-back request pulses
//   uc_rreq_i/uc_wreq_i   uncached word read / write request pulses
//   addr_i                request address (line-aligned for cached requests)
//   wline_i               dirty line data for a write-back
//   uc_wdata_i/uc_wstrb_i uncached write data / byte enables
//   rend_o, wend_o        read / write done pulses (rline_o valid with rend_o)
//   rline_o               read line; word k = bits [32k+31:32k]
//   busy_o                transaction in flight
//   ar*/r*/aw*/w*/b*      AXI4 master channels
// -----------------------------------------------------------------------------
module dcache_axi_bridge #(
   parameter int unsigned     ID_W       = 4,
   parameter logic [ID_W-1:0] AXI_ID     = '0,
   parameter int unsigned     LINE_WORDS = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ca_rreq_i,
   input  logic                    ca_wreq_i,
   input  logic                    uc_rreq_i,
   input  logic                    uc_wreq_i,
   input  logic [31:0]             addr_i,
   input  logic [32*LINE_WORDS-1:0] wline_i,
   input  logic [31:0]             uc_wdata_i,
   input  logic [3:0]              uc_wstrb_i,
   output logic                    rend_o,
   output logic                    wend_o,
   output logic [32*LINE_WORDS-1:0] rline_o,
   output logic                    busy_o,
`ifdef DCACHE_AXI_RESP_CHK_EN
   output logic                    bus_err_o,
`endif
   output logic [ID_W-1:0]         arid,
   output logic [31:0]             araddr,
   output logic [7:0]              arlen,
   output logic [2:0]              arsize,
   output logic [1:0]              arburst,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [ID_W-1:0]         rid,
   input  logic [31:0]             rdata,
   input  logic [1:0]              rresp,
   input  logic                    rlast,
   input  logic                    rvalid,
   output logic                    rready,
   output logic [ID_W-1:0]         awid,
   output logic [31:0]             awaddr,
   output logic [7:0]              awlen,
   output logic [2:0]              awsize,
   output logic [1:0]              awburst,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [31:0]             wdata,
   output logic [3:0]              wstrb,
   output logic                    wlast,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [ID_W-1:0]         bid,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready
);

   localparam int unsigned LW        = 32 * LINE_WORDS;
   localparam int unsigned CNT_W     = $clog2(LINE_WORDS);
   localparam int unsigned OFF_W     = CNT_W + 2;
   localparam logic [7:0]  BURST_LEN = 8'(LINE_WORDS - 1);
   localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_AR,
      S_R,
      S_AW,
      S_W,
      S_B
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        addr_q;
   logic [LW-1:0]      line_q;
   logic [31:0]        uc_wdata_q;
   logic [3:0]         uc_wstrb_q;
   logic               uc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [LW-1:0]      rline_q;
   logic               rend_q, wend_q;

   logic               accept, acc_uc, acc_rd;
   logic [7:0]         len;
   logic [31:0]        line_word;

   // Request arbitration in IDLE: uc_rreq > uc_wreq > ca_rreq > ca_wreq
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      acc_uc  = 1'b0;
      acc_rd  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (uc_rreq_i) begin
               accept = 1'b1; acc_uc = 1'b1; acc_rd = 1'b1;
            end else if (uc_wreq_i) begin
               accept = 1'b1; acc_uc = 1'b1;
            end else if (ca_rreq_i) begin
               accept = 1'b1; acc_rd = 1'b1;
            end else if (ca_wreq_i) begin
               accept = 1'b1;
            end
            if (accept) state_d = acc_rd ? S_AR : S_AW;
         end
         S_AR:    if (arready)         state_d = S_R;
         S_R:     if (rvalid && rlast) state_d = S_IDLE;
         S_AW:    if (awready)         state_d = S_W;
         S_W:     if (wready && wlast) state_d = S_B;
         S_B:     if (bvalid)          state_d = S_IDLE;
         default:                      state_d = S_IDLE;
      endcase
   end

   always_comb line_word = line_q[32*cnt_q +: 32];

   assign len     = uc_q ? 8'd0 : BURST_LEN;

   assign arid    = AXI_ID;
   assign araddr  = uc_q ? addr_q : (addr_q & LINE_MASK);
   assign arlen   = len;
   assign arsize  = 3'd2;
   assign arburst = 2'b01;
   assign arvalid = (state_q == S_AR);
   assign rready  = (state_q == S_R);

   // Write-back address is already the victim line address; no masking.
   assign awid    = AXI_ID;
   assign awaddr  = addr_q;
   assign awlen   = len;
   assign awsize  = 3'd2;
   assign awburst = 2'b01;
   assign awvalid = (state_q == S_AW);

   // cnt only moves on a W handshake, so wdata/wlast hold while stalled.
   assign wdata   = uc_q ? uc_wdata_q : line_word;
   assign wstrb   = uc_q ? uc_wstrb_q : 4'hF;
   assign wlast   = (8'(cnt_q) == len);
   assign wvalid  = (state_q == S_W);
   assign bready  = (state_q == S_B);

   assign rend_o  = rend_q;
   assign wend_o  = wend_q;
   assign rline_o = rline_q;
   assign busy_o  = (state_q != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         line_q     <= '0;
         uc_wdata_q <= '0;
         uc_wstrb_q <= '0;
         uc_q       <= 1'b0;
         cnt_q      <= '0;
         rline_q    <= '0;
         rend_q     <= 1'b0;
         wend_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         rend_q  <= (state_q == S_R) && rvalid && rlast;
         wend_q  <= (state_q == S_B) && bvalid;
         if (accept) begin
            addr_q     <= addr_i;
            line_q     <= wline_i;
            uc_wdata_q <= uc_wdata_i;
            uc_wstrb_q <= uc_wstrb_i;
            uc_q       <= acc_uc;
            cnt_q      <= '0;
         end
         if (state_q == S_R && rvalid) begin
            cnt_q <= cnt_q + 1'b1;
            if (uc_q) rline_q <= {LINE_WORDS{rdata}};
            else      rline_q[32*cnt_q +: 32] <= rdata;
         end
         if (state_q == S_W && wready) cnt_q <= cnt_q + 1'b1;
      end
   end

`ifdef DCACHE_AXI_RESP_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_err_o <= 1'b0;
      end else begin
         if (state_q == S_R && rvalid && (rresp != 2'b00 || rid != AXI_ID))
            bus_err_o <= 1'b1;
         if (state_q == S_B && bvalid && (bresp != 2'b00 || bid != AXI_ID))
            bus_err_o <= 1'b1;
      end
   end
`else
   logic unused_resp;
   assign unused_resp = ^{rid, rresp, bid, bresp};
`endif

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// -----------------------------------------------------------------------------
// tb_dcache_axi_bridge
//   Directed bench for dcache_axi_bridge. The bench plays the AXI slave cycle
//   by cycle and checks each scenario against hand-computed values.
// -----------------------------------------------------------------------------
module tb_dcache_axi_bridge;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ca_rreq_i, ca_wreq_i, uc_rreq_i, uc_wreq_i;
   logic [31:0]  addr_i;
   logic [255:0] wline_i;
   logic [31:0]  uc_wdata_i;
   logic [3:0]   uc_wstrb_i;
   logic         rend_o, wend_o, busy_o;
   logic [255:0] rline_o;
`ifdef DCACHE_AXI_RESP_CHK_EN
   logic         bus_err_o;
`endif
   logic [3:0]   arid, rid, awid, bid;
   logic [31:0]  araddr, rdata, awaddr, wdata;
   logic [7:0]   arlen, awlen;
   logic [2:0]   arsize, awsize;
   logic [1:0]   arburst, awburst, rresp, bresp;
   logic         arvalid, arready, rlast, rvalid, rready;
   logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [3:0]   wstrb;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dcache_axi_bridge #(.ID_W(4), .AXI_ID(4'd0), .LINE_WORDS(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .ca_rreq_i(ca_rreq_i), .ca_wreq_i(ca_wreq_i),
      .uc_rreq_i(uc_rreq_i), .uc_wreq_i(uc_wreq_i),
      .addr_i(addr_i), .wline_i(wline_i),
      .uc_wdata_i(uc_wdata_i), .uc_wstrb_i(uc_wstrb_i),
      .rend_o(rend_o), .wend_o(wend_o), .rline_o(rline_o), .busy_o(busy_o),
`ifdef DCACHE_AXI_RESP_CHK_EN
      .bus_err_o(bus_err_o),
`endif
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
      .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({arvalid, rready, awvalid, wvalid, bready, rend_o, wend_o, busy_o} !== 8'h00) begin
         n_err++;
         $display("FAIL reset_ctrl got %b want 00000000",
                  {arvalid, rready, awvalid, wvalid, bready, rend_o, wend_o, busy_o});
      end
      n_cmp++;
      if (rline_o !== 256'd0) begin
         n_err++; $display("FAIL reset_rline got %h want 0", rline_o);
      end
`ifdef DCACHE_AXI_RESP_CHK_EN
      n_cmp++;
      if (bus_err_o !== 1'b0) begin
         n_err++; $display("FAIL reset_bus_err got %b want 0", bus_err_o);
      end
`endif
   endtask

   // Cached line read at 0x1000_0044: aligned to 0x1000_0040, 8 beats 0..7.
   task automatic test_ca_read();
      logic [255:0] exp;
      for (int k = 0; k < 8; k++) exp[k*32 +: 32] = 32'(k);
      arready = 1'b1;
      addr_i = 32'h1000_0044; ca_rreq_i = 1'b1;
      tick();
      ca_rreq_i = 1'b0;
      n_cmp++;
      if (!(arvalid === 1'b1 && busy_o === 1'b1)) begin
         n_err++; $display("FAIL rd_arvalid got arvalid=%b busy=%b want 1 1", arvalid, busy_o);
      end
      n_cmp++;
      if (araddr !== 32'h1000_0040) begin
         n_err++; $display("FAIL rd_araddr got %h want 10000040", araddr);
      end
      n_cmp++;
      if ({arlen, arsize, arburst, arid} !== {8'd7, 3'd2, 2'b01, 4'd0}) begin
         n_err++; $display("FAIL rd_arfields got len=%0d size=%0d burst=%0d id=%0d want 7 2 1 0",
                           arlen, arsize, arburst, arid);
      end
      tick();
      n_cmp++;
      if (!(rready === 1'b1 && arvalid === 1'b0)) begin
         n_err++; $display("FAIL rd_rready got rready=%b arvalid=%b want 1 0", rready, arvalid);
      end
      for (int k = 0; k < 8; k++) begin
         rvalid = 1'b1; rdata = 32'(k); rlast = (k == 7);
         tick();
         if (k == 3) begin
            n_cmp++;
            if (rend_o !== 1'b0) begin
               n_err++; $display("FAIL rd_rend_early got %b want 0", rend_o);
            end
         end
      end
      rvalid = 1'b0; rlast = 1'b0;
      n_cmp++;
      if (!(rend_o === 1'b1 && busy_o === 1'b0)) begin
         n_err++; $display("FAIL rd_rend got rend=%b busy=%b want 1 0", rend_o, busy_o);
      end
      n_cmp++;
      if (rline_o[63:32] !== 32'd1 || rline_o[255:224] !== 32'd7) begin
         n_err++; $display("FAIL rd_words got w1=%h w7=%h want 1 7", rline_o[63:32], rline_o[255:224]);
      end
      n_cmp++;
      if (rline_o !== exp) begin
         n_err++; $display("FAIL rd_line got %h want %h", rline_o, exp);
      end
      tick();
      n_cmp++;
      if (rend_o !== 1'b0 || rline_o !== exp) begin
         n_err++; $display("FAIL rd_after got rend=%b line=%h want 0 %h", rend_o, rline_o, exp);
      end
   endtask

   // Cached write-back with awready stalled once and wready toggling 1/0.
   task automatic test_ca_write();
      int b;
      for (int k = 0; k < 8; k++) wline_i[k*32 +: 32] = 32'hA0 + 32'(k);
      addr_i = 32'h2000_0020; ca_wreq_i = 1'b1; awready = 1'b0;
      tick();
      ca_wreq_i = 1'b0;
      wline_i = '1;
      n_cmp++;
      if (!(awvalid === 1'b1 && arvalid === 1'b0 && awaddr === 32'h2000_0020 && awlen === 8'd7)) begin
         n_err++; $display("FAIL wr_aw got awvalid=%b arvalid=%b awaddr=%h awlen=%0d want 1 0 20000020 7",
                           awvalid, arvalid, awaddr, awlen);
      end
      tick();
      n_cmp++;
      if (!(awvalid === 1'b1 && awaddr === 32'h2000_0020)) begin
         n_err++; $display("FAIL wr_aw_hold got awvalid=%b awaddr=%h want 1 20000020", awvalid, awaddr);
      end
      awready = 1'b1;
      tick();
      awready = 1'b0;
      b = 0;
      for (int c = 0; c < 20 && b < 8; c++) begin
         wready = ((c % 2) == 0);
         n_cmp++;
         if (!(wvalid === 1'b1 && awvalid === 1'b0 && wdata === 32'hA0 + 32'(b) &&
               wstrb === 4'hF && wlast === (b == 7))) begin
            n_err++;
            $display("FAIL wr_beat%0d got wvalid=%b awvalid=%b wdata=%h wstrb=%h wlast=%b want 1 0 %h f %b",
                     b, wvalid, awvalid, wdata, wstrb, wlast, 32'hA0 + 32'(b), (b == 7));
         end
         if (wready) b++;
         tick();
      end
      wready = 1'b0;
      n_cmp++;
      if (!(b == 8 && bready === 1'b1 && wvalid === 1'b0)) begin
         n_err++; $display("FAIL wr_to_b got beats=%0d bready=%b wvalid=%b want 8 1 0", b, bready, wvalid);
      end
      bvalid = 1'b1; bresp = 2'b00; bid = 4'd0;
      tick();
      bvalid = 1'b0;
      n_cmp++;
      if (!(wend_o === 1'b1 && busy_o === 1'b0 && bready === 1'b0)) begin
         n_err++; $display("FAIL wr_wend got wend=%b busy=%b bready=%b want 1 0 0", wend_o, busy_o, bready);
      end
      tick();
      n_cmp++;
      if (wend_o !== 1'b0) begin
         n_err++; $display("FAIL wr_wend_pulse got %b want 0", wend_o);
      end
   endtask

   task automatic test_uc_write();
      addr_i = 32'h1FAF_F004; uc_wdata_i = 32'h1234_5678; uc_wstrb_i = 4'b0011;
      wline_i = {8{32'h5555_AAAA}};
      uc_wreq_i = 1'b1; awready = 1'b1;
      tick();
      uc_wreq_i = 1'b0; uc_wdata_i = '0; uc_wstrb_i = '0;
      n_cmp++;
      if (!(awvalid === 1'b1 && awaddr === 32'h1FAF_F004 && awlen === 8'd0)) begin
         n_err++; $display("FAIL ucw_aw got awvalid=%b awaddr=%h awlen=%0d want 1 1faff004 0",
                           awvalid, awaddr, awlen);
      end
      tick();
      awready = 1'b0; wready = 1'b1;
      n_cmp++;
      if (!(wvalid === 1'b1 && wdata === 32'h1234_5678 && wstrb === 4'b0011 && wlast === 1'b1)) begin
         n_err++; $display("FAIL ucw_w got wvalid=%b wdata=%h wstrb=%b wlast=%b want 1 12345678 0011 1",
                           wvalid, wdata, wstrb, wlast);
      end
      tick();
      wready = 1'b0;
      n_cmp++;
      if (!(bready === 1'b1 && wvalid === 1'b0)) begin
         n_err++; $display("FAIL ucw_b got bready=%b wvalid=%b want 1 0", bready, wvalid);
      end
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      n_cmp++;
      if (wend_o !== 1'b1) begin
         n_err++; $display("FAIL ucw_wend got %b want 1", wend_o);
      end
      tick();
   endtask

   // uc_rreq wins over a simultaneous ca_wreq; the ca_wreq is dropped.
   task automatic test_priority_uc_read();
      addr_i = 32'h3000_0008; uc_rreq_i = 1'b1; ca_wreq_i = 1'b1; arready = 1'b1;
      tick();
      uc_rreq_i = 1'b0; ca_wreq_i = 1'b0;
      n_cmp++;
      if (!(arvalid === 1'b1 && awvalid === 1'b0 && arlen === 8'd0 && araddr === 32'h3000_0008)) begin
         n_err++; $display("FAIL pri_ar got arvalid=%b awvalid=%b arlen=%0d araddr=%h want 1 0 0 30000008",
                           arvalid, awvalid, arlen, araddr);
      end
      tick();
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rlast = 1'b1;
      tick();
      rvalid = 1'b0; rlast = 1'b0;
      n_cmp++;
      if (!(rend_o === 1'b1 && rline_o === {8{32'hDEAD_BEEF}})) begin
         n_err++; $display("FAIL pri_line got rend=%b line=%h want 1 all deadbeef", rend_o, rline_o);
      end
      tick(); tick();
      n_cmp++;
      if (!(awvalid === 1'b0 && busy_o === 1'b0)) begin
         n_err++; $display("FAIL pri_dropped got awvalid=%b busy=%b want 0 0", awvalid, busy_o);
      end
   endtask

   // Write-back then a refill issued one cycle after wend_o.
   task automatic test_back_to_back();
      logic [255:0] exp;
      int c;
      for (int k = 0; k < 8; k++) exp[k*32 +: 32] = 32'h50 + 32'(k);
      wline_i = {8{32'h0BAD_F00D}};
      addr_i = 32'h4000_0040; ca_wreq_i = 1'b1; awready = 1'b1; wready = 1'b1;
      tick();
      ca_wreq_i = 1'b0;
      c = 0;
      while (bready !== 1'b1 && c < 20) begin tick(); c++; end
      n_cmp++;
      if (bready !== 1'b1) begin
         n_err++; $display("FAIL b2b_wr_timeout got bready=%b want 1", bready);
      end
      awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      n_cmp++;
      if (wend_o !== 1'b1) begin
         n_err++; $display("FAIL b2b_wend got %b want 1", wend_o);
      end
      tick();
      addr_i = 32'h4000_0040; ca_rreq_i = 1'b1; arready = 1'b1;
      tick();
      ca_rreq_i = 1'b0;
      n_cmp++;
      if (!(arvalid === 1'b1 && araddr === 32'h4000_0040 && arlen === 8'd7)) begin
         n_err++; $display("FAIL b2b_ar got arvalid=%b araddr=%h arlen=%0d want 1 40000040 7",
                           arvalid, araddr, arlen);
      end
      tick();
      for (int k = 0; k < 8; k++) begin
         rvalid = 1'b1; rdata = 32'h50 + 32'(k); rlast = (k == 7);
         tick();
      end
      rvalid = 1'b0; rlast = 1'b0;
      n_cmp++;
      if (!(rend_o === 1'b1 && rline_o === exp)) begin
         n_err++; $display("FAIL b2b_rd got rend=%b line=%h want 1 %h", rend_o, rline_o, exp);
      end
      tick();
   endtask

   // Asynchronous reset in the middle of a read burst, then a clean refill.
   task automatic test_reset_mid_read();
      logic [255:0] exp;
      for (int k = 0; k < 8; k++) exp[k*32 +: 32] = 32'h60 + 32'(k);
      addr_i = 32'h5000_0000; ca_rreq_i = 1'b1; arready = 1'b1;
      tick();
      ca_rreq_i = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         rvalid = 1'b1; rdata = 32'h99; rlast = 1'b0;
         tick();
      end
      rvalid = 1'b1; rdata = 32'h99;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({arvalid, rready, awvalid, wvalid, bready, rend_o, wend_o, busy_o} !== 8'h00) begin
         n_err++; $display("FAIL rst_mid_ctrl got %b want 00000000",
                           {arvalid, rready, awvalid, wvalid, bready, rend_o, wend_o, busy_o});
      end
      n_cmp++;
      if (rline_o !== 256'd0) begin
         n_err++; $display("FAIL rst_mid_rline got %h want 0", rline_o);
      end
      rvalid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      addr_i = 32'h5000_0010; ca_rreq_i = 1'b1;
      tick();
      ca_rreq_i = 1'b0;
      n_cmp++;
      if (!(arvalid === 1'b1 && araddr === 32'h5000_0000)) begin
         n_err++; $display("FAIL rst_re_ar got arvalid=%b araddr=%h want 1 50000000", arvalid, araddr);
      end
      tick();
      for (int k = 0; k < 8; k++) begin
         rvalid = 1'b1; rdata = 32'h60 + 32'(k); rlast = (k == 7);
         rresp = (k == 2) ? 2'd2 : 2'd0;
         tick();
      end
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
      n_cmp++;
      if (!(rend_o === 1'b1 && rline_o === exp)) begin
         n_err++; $display("FAIL rst_re_line got rend=%b line=%h want 1 %h", rend_o, rline_o, exp);
      end
`ifdef DCACHE_AXI_RESP_CHK_EN
      n_cmp++;
      if (bus_err_o !== 1'b1) begin
         n_err++; $display("FAIL rst_re_bus_err got %b want 1", bus_err_o);
      end
`endif
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      ca_rreq_i = 1'b0; ca_wreq_i = 1'b0; uc_rreq_i = 1'b0; uc_wreq_i = 1'b0;
      addr_i = '0; wline_i = '0; uc_wdata_i = '0; uc_wstrb_i = '0;
      arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
      awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      tick();
      test_ca_read();
      test_ca_write();
      test_uc_write();
      test_priority_uc_read();
      test_back_to_back();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
